ring_port_arbiter: RTL

RING_PORT_ARBITER -- requirements
Module: ring_port_arbiter

---
 rtl/ring_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ring_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ring_port_arbiter
// Function : Merges pass-through and local ring beats into one output FIFO,
//            bounding how long a waiting local beat can be starved.
// Revision : 1.0
// ============================================================================
module ring_port_arbiter #(
    parameter type         data_t       = logic,
    parameter int unsigned FifoDepth    = 2,
    parameter int unsigned MaxThruBurst = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  data_t                          thru_i,
    input  logic                           thru_valid_i,
    output logic                           thru_ready_o,
    input  data_t                          local_i,
    input  logic                           local_valid_i,
    output logic                           local_ready_o,
    output data_t                          ring_o,
    output logic                           ring_valid_o,
    input  logic                           ring_ready_i,
    output logic [$clog2(FifoDepth+1)-1:0] usage_o,
    output logic                           local_prio_o
);

    localparam int unsigned c_CNT_W   = $clog2(FifoDepth + 1);
    localparam int unsigned c_PTR_W   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned c_BURST_W = $clog2(MaxThruBurst + 1);

    localparam logic [c_CNT_W-1:0]   c_FULL       = c_CNT_W'(FifoDepth);
    localparam logic [c_PTR_W-1:0]   c_LAST_PTR   = c_PTR_W'(FifoDepth - 1);
    localparam logic [c_BURST_W-1:0] c_LAST_BURST = c_BURST_W'(MaxThruBurst - 1);

    typedef enum logic [0:0] {
        THRU_PRIO  = 1'b0,
        LOCAL_PRIO = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_BURST_W-1:0] r_burst;
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_usage;
    data_t                r_mem [FifoDepth];

    logic  w_can_grant;
    logic  w_grant_thru;
    logic  w_grant_local;
    logic  w_push;
    logic  w_pop;
    data_t w_push_data;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    // Grant depends only on registered occupancy, never on this cycle's pop.
    assign w_can_grant = rst_ni && (r_usage != c_FULL);

    always_comb begin
        w_grant_thru  = 1'b0;
        w_grant_local = 1'b0;
        if (w_can_grant) begin
            if (r_state == LOCAL_PRIO) begin
                if (local_valid_i)     w_grant_local = 1'b1;
                else if (thru_valid_i) w_grant_thru  = 1'b1;
            end else begin
                if (thru_valid_i)       w_grant_thru  = 1'b1;
                else if (local_valid_i) w_grant_local = 1'b1;
            end
        end
    end

    assign thru_ready_o  = w_grant_thru;
    assign local_ready_o = w_grant_local;
    assign w_push        = w_grant_thru | w_grant_local;
    assign w_push_data   = w_grant_local ? local_i : thru_i;
    assign w_pop         = ring_valid_o & ring_ready_i;

    // The counter only reaches MaxThruBurst-1 before handing priority to local.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= THRU_PRIO;
            r_burst <= '0;
        end else begin
            if (!local_valid_i || w_grant_local) begin
                r_burst <= '0;
            end else if (w_grant_thru) begin
                r_burst <= (r_burst == c_LAST_BURST) ? '0 : r_burst + c_BURST_W'(1);
            end

            case (r_state)
                THRU_PRIO: begin
                    if (local_valid_i && w_grant_thru && (r_burst == c_LAST_BURST))
                        r_state <= LOCAL_PRIO;
                end
                LOCAL_PRIO: begin
                    if (w_grant_local || !local_valid_i)
                        r_state <= THRU_PRIO;
                end
                default: r_state <= THRU_PRIO;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_usage <= '0;
        end else begin
            if (w_push) r_wptr <= f_next_ptr(r_wptr);
            if (w_pop)  r_rptr <= f_next_ptr(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_usage <= r_usage + c_CNT_W'(1);
                2'b01:   r_usage <= r_usage - c_CNT_W'(1);
                default: r_usage <= r_usage;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= w_push_data;
    end

    assign ring_o       = r_mem[r_rptr];
    assign ring_valid_o = (r_usage != '0);
    assign usage_o      = r_usage;
    assign local_prio_o = (r_state == LOCAL_PRIO);

endmodule
`default_nettype wire
